// File: rtl/song_player_ctrl_if.sv
// Control, status and song-ROM signals of the song player sequencer.
// The master side drives control and ROM data; the slave side is the sequencer.
interface song_player_ctrl_if;
    logic        play;
    logic        stop;
    logic        pause;
    logic        loop_en;
    logic [3:0]  song_sel;
    logic [3:0]  rom_note;
    logic [15:0] rom_duration;
    logic [4:0]  rom_address;
    logic [3:0]  rom_song;
    logic [3:0]  note_out;
    logic        note_valid;
    logic        busy;
    logic        song_done;

    modport master (
        output play, stop, pause, loop_en, song_sel, rom_note, rom_duration,
        input  rom_address, rom_song, note_out, note_valid, busy, song_done
    );

    modport slave (
        input  play, stop, pause, loop_en, song_sel, rom_note, rom_duration,
        output rom_address, rom_song, note_out, note_valid, busy, song_done
    );
endinterface

// File: rtl/song_player_ctrl.sv
// Song sequencer: walks the song ROM, times each entry with a prescaled tick and
// inserts a silence gap at the end of every note so repeated notes stay distinct.
module song_player_ctrl #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned GAP_TICKS = 200
) (
    input logic               clk,
    input logic               rst_n,
    song_player_ctrl_if.slave io_bus
);

    localparam int unsigned PsW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PsW-1:0] PsMax = PsW'(TICK_DIV - 1);
    localparam logic [15:0] GapLen  = 16'(GAP_TICKS);

    typedef enum logic [2:0] {StIdle, StFetch, StPlay, StGap, StDone} state_e;

    state_e         r_state;
    logic [PsW-1:0] r_presc;
    logic [15:0]    r_cnt;
    logic [15:0]    r_gap;
    logic [4:0]     r_addr;
    logic [3:0]     r_song;
    logic [3:0]     r_note;
    logic           r_valid;

    logic        w_run;
    logic        w_tick;
    logic        w_cnt_last;
    logic        w_advance;
    logic [15:0] w_play_len;
    logic [15:0] w_gap_len;

    assign w_run      = (r_state == StPlay || r_state == StGap) && !io_bus.pause;
    assign w_tick     = w_run && (r_presc == PsMax);
    assign w_cnt_last = (r_cnt == 16'd1);
    // Note slot finished: end of gap, or end of play when the entry has no gap.
    assign w_advance  = w_tick && w_cnt_last &&
                        (r_state == StGap || (r_state == StPlay && r_gap == 16'd0));

    always_comb begin
        if (io_bus.rom_duration > GapLen) begin
            w_play_len = io_bus.rom_duration - GapLen;
            w_gap_len  = GapLen;
        end else begin
            w_play_len = io_bus.rom_duration;
            w_gap_len  = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_presc <= '0;
            r_cnt   <= 16'd0;
            r_gap   <= 16'd0;
            r_addr  <= 5'd0;
            r_song  <= 4'd0;
            r_note  <= 4'd0;
            r_valid <= 1'b0;
        end else if (io_bus.stop) begin
            r_state <= StIdle;
            r_presc <= '0;
            r_cnt   <= 16'd0;
            r_addr  <= 5'd0;
            r_note  <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            if (w_run) begin
                r_presc <= (r_presc == PsMax) ? '0 : r_presc + 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    if (io_bus.play) begin
                        r_song  <= io_bus.song_sel;
                        r_addr  <= 5'd0;
                        r_presc <= '0;
                        r_state <= StFetch;
                    end
                end
                StFetch: begin
                    if (io_bus.rom_duration == 16'd0) begin
                        // Looping from address 0 would spin forever on an empty song.
                        if (io_bus.loop_en && r_addr != 5'd0) begin
                            r_addr <= 5'd0;
                        end else begin
                            r_note  <= 4'd0;
                            r_valid <= 1'b0;
                            r_state <= StDone;
                        end
                    end else begin
                        r_cnt   <= w_play_len;
                        r_gap   <= w_gap_len;
                        r_note  <= io_bus.rom_note;
                        r_valid <= (io_bus.rom_note != 4'd0);
                        r_state <= StPlay;
                    end
                end
                StPlay: begin
                    if (io_bus.pause) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= (r_note != 4'd0);
                        if (w_tick) begin
                            if (!w_cnt_last) begin
                                r_cnt <= r_cnt - 16'd1;
                            end else if (r_gap != 16'd0) begin
                                r_cnt   <= r_gap;
                                r_valid <= 1'b0;
                                r_state <= StGap;
                            end
                        end
                    end
                end
                StGap: begin
                    if (w_tick && !w_cnt_last) begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                StDone: begin
                    r_addr  <= 5'd0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase

            if (w_advance) begin
                r_valid <= 1'b0;
                r_presc <= '0;
                if (r_addr == 5'd31 && !io_bus.loop_en) begin
                    r_note  <= 4'd0;
                    r_state <= StDone;
                end else begin
                    r_addr  <= (r_addr == 5'd31) ? 5'd0 : r_addr + 5'd1;
                    r_state <= StFetch;
                end
            end
        end
    end

    assign io_bus.rom_address = r_addr;
    assign io_bus.rom_song    = r_song;
    assign io_bus.note_out    = r_note;
    assign io_bus.note_valid  = r_valid;
    assign io_bus.busy        = (r_state != StIdle);
    assign io_bus.song_done   = (r_state == StDone);

endmodule
